// File: rtl/block_dispatcher_if.sv
// ---------------------------------------------------------------------------
// block_dispatcher_if
//
// Purpose: dispatcher <-> compute core array handshake bundle.
//
// Signals (NUM_CORES lanes, lane i belongs to core i):
//   core_reset        dispatcher -> core  one-cycle reset pulse before a block
//   core_start        dispatcher -> core  run enable, held until core_done
//   core_block_id     dispatcher -> core  block index, core i uses [8i+7:8i]
//   core_thread_count dispatcher -> core  active threads, core i uses [8i+7:8i]
//   core_done         core -> dispatcher  block-finished level
//
// Modports: master (dispatcher side), slave (core array side).
// ---------------------------------------------------------------------------
interface block_dispatcher_if #(
  parameter int NUM_CORES = 2
) ();

  logic [NUM_CORES-1:0]   core_reset;
  logic [NUM_CORES-1:0]   core_start;
  logic [NUM_CORES*8-1:0] core_block_id;
  logic [NUM_CORES*8-1:0] core_thread_count;
  logic [NUM_CORES-1:0]   core_done;

  modport master (
    output core_reset,
    output core_start,
    output core_block_id,
    output core_thread_count,
    input  core_done
  );

  modport slave (
    input  core_reset,
    input  core_start,
    input  core_block_id,
    input  core_thread_count,
    output core_done
  );

endinterface

// File: rtl/block_dispatcher.sv
// ---------------------------------------------------------------------------
// block_dispatcher
//
// Purpose: kernel launch dispatcher. Latches the launch thread count, splits
// it into THREADS_PER_BLOCK-sized blocks and hands them to compute cores via
// a reset/start/done handshake, then reports kernel completion to the host.
//
// Parameters:
//   NUM_CORES          number of cores served (1..8)
//   THREADS_PER_BLOCK  threads per block, power of two (1..128)
//
// Ports:
//   clk           clock, rising edge
//   reset_n       asynchronous active-low reset
//   start         launch request level, held by the host until done
//   thread_count  total threads, sampled only on launch
//   done          kernel complete
//   perf_cycles   RUN-state cycle counter (saturating), 0 when disabled
//   cores         block_dispatcher_if.master core handshake bundle
//
// Optional feature: define BLOCK_DISPATCHER_PERF_EN to build the busy-cycle
// counter; otherwise perf_cycles is tied to zero.
// ---------------------------------------------------------------------------
module block_dispatcher #(
  parameter int NUM_CORES         = 2,
  parameter int THREADS_PER_BLOCK = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [7:0]               thread_count,
  output logic                     done,
  output logic [15:0]              perf_cycles,
  block_dispatcher_if.master       cores
);

  localparam int         TPB_SHIFT = $clog2(THREADS_PER_BLOCK);
  localparam logic [7:0] TPB8      = 8'(THREADS_PER_BLOCK);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;
  typedef enum logic [1:0] {SL_FREE, SL_RESET, SL_BUSY} slot_e;

  // ceil(t / THREADS_PER_BLOCK); the 9-bit sum keeps the carry of t + TPB-1.
  function automatic logic [7:0] blocks_for(input logic [7:0] t);
    logic [8:0] sum;
    sum = {1'b0, t} + 9'(THREADS_PER_BLOCK - 1);
    return 8'(sum >> TPB_SHIFT);
  endfunction

  // Threads remaining from this block's first thread, capped at a full block.
  // Only the last block ever sees fewer than THREADS_PER_BLOCK remaining.
  function automatic logic [7:0] threads_in_block(input logic [7:0] t,
                                                  input logic [7:0] id);
    logic [7:0] rem;
    rem = t - 8'(id << TPB_SHIFT);
    return (rem >= TPB8) ? TPB8 : rem;
  endfunction

  state_e                 state_q, state_d;
  slot_e                  slot_q [NUM_CORES];
  slot_e                  slot_d [NUM_CORES];
  logic [7:0]             t_q, t_d;
  logic [7:0]             total_q, total_d;
  logic [7:0]             disp_q, disp_d;
  logic [7:0]             bdone_q, bdone_d;
  logic                   done_q, done_d;
  logic [NUM_CORES-1:0]   core_reset_q, core_reset_d;
  logic [NUM_CORES-1:0]   core_start_q, core_start_d;
  logic [NUM_CORES*8-1:0] block_id_q, block_id_d;
  logic [NUM_CORES*8-1:0] blk_cnt_q, blk_cnt_d;

  logic [7:0]             next_id;
  logic [7:0]             n_fin;

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    t_d          = t_q;
    total_d      = total_q;
    disp_d       = disp_q;
    bdone_d      = bdone_q;
    done_d       = done_q;
    core_reset_d = core_reset_q;
    core_start_d = core_start_q;
    block_id_d   = block_id_q;
    blk_cnt_d    = blk_cnt_q;
    next_id      = disp_q;
    n_fin        = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_RUN;
          t_d          = thread_count;
          total_d      = blocks_for(thread_count);
          disp_d       = '0;
          bdone_d      = '0;
          core_reset_d = '0;
          core_start_d = '0;
          slot_d       = '{default: SL_FREE};
        end
      end

      ST_RUN: begin
        // Completion is judged on the registered count, so done follows the
        // edge after the last core_done was counted. A zero-block kernel
        // therefore leaves RUN on its first RUN edge.
        if (bdone_q == total_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          // Ascending core index gets the lowest pending block id; several
          // free slots may be filled on the same edge.
          for (int i = 0; i < NUM_CORES; i++) begin
            unique case (slot_q[i])
              SL_FREE: begin
                if (next_id < total_q) begin
                  slot_d[i]              = SL_RESET;
                  core_reset_d[i]        = 1'b1;
                  block_id_d[8*i +: 8]   = next_id;
                  blk_cnt_d[8*i +: 8]    = threads_in_block(t_q, next_id);
                  next_id                = next_id + 8'd1;
                end
              end
              SL_RESET: begin
                slot_d[i]       = SL_BUSY;
                core_reset_d[i] = 1'b0;
                core_start_d[i] = 1'b1;
              end
              SL_BUSY: begin
                // A freed slot is not refilled on this edge, which leaves a
                // one-cycle gap before the core's next reset pulse.
                if (cores.core_done[i]) begin
                  slot_d[i]       = SL_FREE;
                  core_start_d[i] = 1'b0;
                  n_fin           = n_fin + 8'd1;
                end
              end
              default: slot_d[i] = SL_FREE;
            endcase
          end
          disp_d  = next_id;
          bdone_d = bdone_q + n_fin;
        end
      end

      ST_DONE: begin
        if (!start) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      for (int i = 0; i < NUM_CORES; i++) slot_q[i] <= SL_FREE;
      t_q          <= '0;
      total_q      <= '0;
      disp_q       <= '0;
      bdone_q      <= '0;
      done_q       <= 1'b0;
      core_reset_q <= '0;
      core_start_q <= '0;
      block_id_q   <= '0;
      blk_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      t_q          <= t_d;
      total_q      <= total_d;
      disp_q       <= disp_d;
      bdone_q      <= bdone_d;
      done_q       <= done_d;
      core_reset_q <= core_reset_d;
      core_start_q <= core_start_d;
      block_id_q   <= block_id_d;
      blk_cnt_q    <= blk_cnt_d;
    end
  end

`ifdef BLOCK_DISPATCHER_PERF_EN
  logic [15:0] perf_q, perf_d;

  // Cleared on launch, counts every RUN cycle, holds through DONE and IDLE.
  always_comb begin
    perf_d = perf_q;
    if (state_q == ST_IDLE && start) begin
      perf_d = '0;
    end else if (state_q == ST_RUN && perf_q != 16'hFFFF) begin
      perf_d = perf_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) perf_q <= '0;
    else          perf_q <= perf_d;
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

  assign done                    = done_q;
  assign cores.core_reset        = core_reset_q;
  assign cores.core_start        = core_start_q;
  assign cores.core_block_id     = block_id_q;
  assign cores.core_thread_count = blk_cnt_q;

endmodule

// File: tb/tb_block_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_block_dispatcher
//
// Bench for block_dispatcher (NUM_CORES=2, THREADS_PER_BLOCK=4). Emulates the
// core array (configurable or random block latency, optional spurious
// core_done on idle cores) and compares every output every cycle against a
// behavioural model built from block bookkeeping (pending ids, per-core
// resetting/running flags, completed-block count).
// ---------------------------------------------------------------------------
module tb_block_dispatcher;

  localparam int NC  = 2;
  localparam int TPB = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  thread_count;
  logic        done;
  logic [15:0] perf_cycles;

  block_dispatcher_if #(.NUM_CORES(NC)) bus ();

  block_dispatcher #(
    .NUM_CORES        (NC),
    .THREADS_PER_BLOCK(TPB)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .thread_count(thread_count),
    .done        (done),
    .perf_cycles (perf_cycles),
    .cores       (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // reference model state
  bit m_run, m_fin;
  int m_T, m_nblk, m_issued, m_completed, m_perf;
  bit m_rst  [NC];
  bit m_busy [NC];
  int m_id   [NC];
  int m_cnt  [NC];

  // core emulation state
  int lat_cfg;
  bit spurious;
  bit scramble;
  int run_cnt    [NC];
  int lat_now    [NC];
  bit prev_start [NC];
  int resets_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_fin = 0; m_T = 0; m_nblk = 0;
    m_issued = 0; m_completed = 0; m_perf = 0;
    for (int i = 0; i < NC; i++) begin
      m_rst[i] = 0; m_busy[i] = 0; m_id[i] = 0; m_cnt[i] = 0;
    end
  endtask

  // One clock edge of the kernel-launch rules, applied to the sampled inputs.
  task automatic model_edge();
    logic [NC-1:0] cd;
    int rem;
    cd = bus.core_done;
    if (m_run) begin
      if (m_perf < 65535) m_perf++;
      if (m_completed == m_nblk) begin
        m_run = 0;
        m_fin = 1;
      end else begin
        for (int i = 0; i < NC; i++) begin
          if (m_busy[i]) begin
            if (cd[i]) begin
              m_busy[i] = 0;
              m_completed++;
            end
          end else if (m_rst[i]) begin
            m_rst[i]  = 0;
            m_busy[i] = 1;
          end else if (m_issued < m_nblk) begin
            rem       = m_T - m_issued * TPB;
            m_rst[i]  = 1;
            m_id[i]   = m_issued;
            m_cnt[i]  = (rem < TPB) ? rem : TPB;
            m_issued++;
          end
        end
      end
    end else if (m_fin) begin
      if (!start) m_fin = 0;
    end else if (start) begin
      m_run       = 1;
      m_T         = int'(thread_count);
      m_nblk      = (m_T + TPB - 1) / TPB;
      m_issued    = 0;
      m_completed = 0;
      m_perf      = 0;
    end
  endtask

  task automatic check_all();
    logic [NC-1:0]   er, es;
    logic [NC*8-1:0] eid, ecnt;
    int              eperf;
    for (int i = 0; i < NC; i++) begin
      er[i]           = m_rst[i];
      es[i]           = m_busy[i];
      eid[8*i +: 8]   = 8'(m_id[i]);
      ecnt[8*i +: 8]  = 8'(m_cnt[i]);
    end
`ifdef BLOCK_DISPATCHER_PERF_EN
    eperf = m_perf;
`else
    eperf = 0;
`endif
    check("done",              32'(done),                  32'(m_fin));
    check("core_reset",        32'(bus.core_reset),        32'(er));
    check("core_start",        32'(bus.core_start),        32'(es));
    check("core_block_id",     32'(bus.core_block_id),     32'(eid));
    check("core_thread_count", 32'(bus.core_thread_count), 32'(ecnt));
    check("perf_cycles",       32'(perf_cycles),           32'(eperf));
  endtask

  task automatic drive_cores();
    logic [NC-1:0] cd;
    cd = '0;
    for (int i = 0; i < NC; i++) begin
      if (bus.core_start[i]) begin
        if (!prev_start[i]) begin
          run_cnt[i] = 0;
          lat_now[i] = (lat_cfg < 0) ? int'($urandom_range(0, 4)) : lat_cfg;
        end
        cd[i]         = (run_cnt[i] >= lat_now[i]);
        run_cnt[i]++;
        prev_start[i] = 1;
      end else begin
        prev_start[i] = 0;
        cd[i]         = spurious ? ($urandom_range(0, 3) == 0) : 1'b0;
      end
    end
    bus.core_done = cd;
    resets_seen += $countones(bus.core_reset);
    if (scramble && m_run) thread_count = 8'($urandom);
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) model_edge();
    #1;
    check_all();
    drive_cores();
  endtask

  task automatic wait_done(input string tag, input int limit);
    int n;
    n = 0;
    while (!done && n < limit) begin
      tick();
      n++;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  task automatic run_kernel(input int t, input int lat, input bit spur);
    lat_cfg      = lat;
    spurious     = spur;
    thread_count = 8'(t);
    start        = 1'b1;
    resets_seen  = 0;
    tick();
    scramble = 1;
    wait_done("kernel_done_bound", 2000);
    scramble = 0;
    check("blocks_issued", 32'(resets_seen), 32'((t + TPB - 1) / TPB));
    start = 1'b0;
    tick();
    check("done_after_start_drop", 32'(done), 32'd0);
    tick();
  endtask

  initial begin
    reset_n       = 1'b0;
    start         = 1'b0;
    thread_count  = '0;
    bus.core_done = '0;
    lat_cfg       = 3;
    spurious      = 0;
    scramble      = 0;
    resets_seen   = 0;
    for (int i = 0; i < NC; i++) begin
      run_cnt[i] = 0; lat_now[i] = 0; prev_start[i] = 0;
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset_n = 1'b1;
    tick();

    // T=8, both blocks issued together, 3-cycle cores
    lat_cfg      = 3;
    thread_count = 8'd8;
    start        = 1'b1;
    resets_seen  = 0;
    tick();
    check("t8_no_reset_at_launch", 32'(bus.core_reset), 32'd0);
    tick();
    check("t8_reset_both",  32'(bus.core_reset),        32'h3);
    check("t8_ids",         32'(bus.core_block_id),     32'h0100);
    check("t8_counts",      32'(bus.core_thread_count), 32'h0404);
    tick();
    check("t8_start_both",  32'(bus.core_start),        32'h3);
    wait_done("t8_done_bound", 100);
    start = 1'b0;
    tick();
    tick();

    // T=10, third block carries 2 threads
    run_kernel(10, 2, 0);
    // T=255, last block carries 3 threads
    run_kernel(255, -1, 1);
    // single block with spurious core_done on the idle core
    run_kernel(4, 4, 1);

    // T=0: no core activity, done within two edges, drops after start drops
    spurious     = 0;
    thread_count = 8'd0;
    start        = 1'b1;
    resets_seen  = 0;
    tick();
    check("t0_done_low_after_launch", 32'(done), 32'd0);
    tick();
    tick();
    check("t0_done", 32'(done), 32'd1);
    check("t0_no_core_reset", 32'(resets_seen), 32'd0);
    start = 1'b0;
    tick();
    check("t0_done_drop", 32'(done), 32'd0);
    tick();

    // reset while cores are busy, then relaunch
    lat_cfg      = 6;
    thread_count = 8'd40;
    start        = 1'b1;
    repeat (6) tick();
    reset_n = 1'b0;
    #1;
    check("rst_done",       32'(done),                  32'd0);
    check("rst_core_reset", 32'(bus.core_reset),        32'd0);
    check("rst_core_start", 32'(bus.core_start),        32'd0);
    check("rst_block_id",   32'(bus.core_block_id),     32'd0);
    check("rst_thread_cnt", 32'(bus.core_thread_count), 32'd0);
    check("rst_perf",       32'(perf_cycles),           32'd0);
    model_reset();
    bus.core_done = '0;
    for (int i = 0; i < NC; i++) prev_start[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_n      = 1'b1;
    thread_count = 8'd12;
    lat_cfg      = 1;
    tick();
    tick();
    check("relaunch_reset0",   32'(bus.core_reset[0]),         32'd1);
    check("relaunch_block0",   32'(bus.core_block_id[7:0]),    32'd0);
    wait_done("relaunch_done_bound", 200);
    start = 1'b0;
    tick();
    tick();

    // T=4 with a 5-cycle core: perf_cycles tracks the RUN cycles
    run_kernel(4, 5, 0);

    // randomized launches
    for (int k = 0; k < 12; k++) begin
      run_kernel(int'($urandom_range(0, 60)), -1, 1);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
